// File: rtl/unidade_busca.sv
// Instruction fetch unit for the single-cycle MIPS core: owns the PC, fetches over a
// req/valid handshake, and holds the fetched word in IR until the datapath retires it.
module unidade_busca #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_done,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_timeout,
  output logic [31:0] instr_count
);

  localparam int unsigned       WAIT_W    = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_RETRY = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       seq_pc;
  logic [31:0]       next_pc;

  function automatic logic [31:0] branch_target(input logic [31:0] seq,
                                                input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return seq + $unsigned(off);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] seq,
                                              input logic [25:0] idx);
    return {seq[31:28], idx, 2'b00};
  endfunction

  assign seq_pc = pc_q + 32'd4;

  // Jump outranks a taken branch; branch/zero/jump matter only on the instr_done cycle.
  always_comb begin
    next_pc = seq_pc;
    if (jump) begin
      next_pc = jump_target(seq_pc, ir_q[25:0]);
    end else if (branch && zero) begin
      next_pc = branch_target(seq_pc, ir_q[15:0]);
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = S_ISSUE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          wait_d    = '0;
          state_d   = S_RETRY;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RETRY: state_d = S_FETCH;
      S_ISSUE: begin
        if (instr_done) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = pc_q;
  assign instr         = ir_q;
  assign opcode        = ir_q[31:26];
  assign instr_valid   = (state_q == S_ISSUE);
  assign pc            = pc_q;
  assign pc_plus4      = seq_pc;
  assign fetch_timeout = timeout_q;
  assign instr_count   = count_q;

endmodule
